// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide scheduler.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    localparam int unsigned MULT_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF  = 10;

    typedef logic [63:0] mdu_res_t;

endpackage

// File: rtl/mdu_busy_ctr.sv
// Latency down-counter; done pulses in the last busy cycle (commit strobe).
module mdu_busy_ctr (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] value,
    output logic       done
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;
    assign done  = (cnt_q == 4'd1);

endmodule

// File: rtl/mdu_sched.sv
// EX-stage MDU scheduler: HI/LO ownership, latency modelling and stall generation.
module mdu_sched
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MD_Valid,
    input  logic        Start,
    input  logic        Add,
    input  logic        HiLo,
    input  logic        WriteEnabled,
    input  logic [1:0]  MDU_Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HiLoOut
);

    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;
    logic        p_wr_q, p_wr_d;

    logic        accept, mt_wr, is_div, done;
    logic [3:0]  cnt;
    logic [3:0]  ld_val;

    mdu_res_t    mul_s, mul_u, res;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
    logic        sgn_div;

    assign Busy    = (cnt != 4'd0);
    assign Stall   = MD_Valid & Busy;
    assign HiLoOut = HiLo ? lo_q : hi_q;

    assign accept = MD_Valid & ~Busy & (Start | Add);
    assign mt_wr  = MD_Valid & ~Busy & WriteEnabled & ~Start & ~Add;
    assign is_div = Start & MDU_Op[1];
    assign ld_val = is_div ? DIV_LD : MULT_LD;

    mdu_busy_ctr u_ctr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .load_val (ld_val),
        .value    (cnt),
        .done     (done)
    );

    // Signed divide via magnitudes so INT_MIN / -1 wraps to INT_MIN cleanly.
    always_comb begin
        mul_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        mul_u   = {32'd0, A} * {32'd0, B};
        sgn_div = (MDU_Op == MDU_DIV);
        a_mag   = (sgn_div && A[31]) ? (~A + 32'd1) : A;
        b_mag   = (sgn_div && B[31]) ? (~B + 32'd1) : B;
        q_mag   = 32'd0;
        r_mag   = 32'd0;
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quo = (sgn_div && (A[31] ^ B[31])) ? (~q_mag + 32'd1) : q_mag;
        rem = (sgn_div && A[31]) ? (~r_mag + 32'd1) : r_mag;
        res = {hi_q, lo_q} + mul_s;
        if (Start) begin
            case (MDU_Op)
                MDU_MULTU: res = mul_u;
                MDU_MULT:  res = mul_s;
                default:   res = {rem, quo};
            endcase
        end
    end

    always_comb begin
        p_hi_d = p_hi_q;
        p_lo_d = p_lo_q;
        p_wr_d = p_wr_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (accept) begin
            p_hi_d = res[63:32];
            p_lo_d = res[31:0];
            p_wr_d = ~(is_div && (B == 32'd0));
        end
        if (done && p_wr_q) begin
            hi_d = p_hi_q;
            lo_d = p_lo_q;
        end
        if (mt_wr) begin
            if (HiLo) begin
                lo_d = A;
            end else begin
                hi_d = A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            p_hi_q <= 32'd0;
            p_lo_q <= 32'd0;
            p_wr_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            p_hi_q <= p_hi_d;
            p_lo_q <= p_lo_d;
            p_wr_q <= p_wr_d;
        end
    end

endmodule
